// File: rtl/present_pkg.sv
// Shared constants, S-box tables, FSM encoding and inverse bit permutation
// for the PRESENT-80 datapaths.
package present_pkg;

  localparam int unsigned ROUNDS  = 31;
  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 80;
  localparam int unsigned RC_W    = 5;
  localparam int unsigned NIB_W   = 4;

  // Nibble tables, entry i lives at bits [4i+3:4i]
  localparam logic [63:0] SBOX_TABLE     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] INV_SBOX_TABLE = 64'hA970_364B_D21C_8FE5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEXP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fsm_e;

  // Undo the pLayer: bit P(i) of the input lands back at bit i
  function automatic logic [BLOCK_W-1:0] inv_perm(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BLOCK_W - 1; i++) begin
      r[6'(i)] = d[6'((16 * i) % 63)];
    end
    r[BLOCK_W-1] = d[BLOCK_W-1];
    return r;
  endfunction

endpackage

// File: rtl/present_inv_sbox.sv
// Inverse PRESENT 4-bit S-box.
module present_inv_sbox
  import present_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [NIB_W-1:0] sub_c
);

  assign sub_c = INV_SBOX_TABLE[{nib, 2'b00} +: NIB_W];

endmodule

// File: rtl/present_sbox.sv
// Forward PRESENT 4-bit S-box, shared with the encrypt datapath.
module present_sbox
  import present_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [NIB_W-1:0] sub_c
);

  assign sub_c = SBOX_TABLE[{nib, 2'b00} +: NIB_W];

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption: 31 forward key-schedule steps to reach
// K32, then 31 inverse rounds walking the key schedule backwards.
module present_decrypt
  import present_pkg::*;
#(
  parameter int unsigned ROUNDS = present_pkg::ROUNDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_ct,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_pt
);

  localparam logic [RC_W-1:0] LAST_RC  = RC_W'(ROUNDS);
  localparam logic [RC_W-1:0] FIRST_RC = RC_W'(1);

  fsm_e               fsm_q;
  fsm_e               fsm_d;
  logic [BLOCK_W-1:0] state;
  logic [KEY_W-1:0]   key;
  logic [RC_W-1:0]    rc;

  logic [NIB_W-1:0]   key_fwd_nib;
  logic [NIB_W-1:0]   key_inv_nib;
  logic [KEY_W-1:0]   key_fwd;
  logic [KEY_W-1:0]   key_inv;
  logic [BLOCK_W-1:0] perm_out;
  logic [BLOCK_W-1:0] sub_out;
  logic [BLOCK_W-1:0] round_out;

  // One forward key-schedule step; s is S(k[18:15]), the nibble rotated to the top
  function automatic logic [KEY_W-1:0] fk(input logic [KEY_W-1:0] k,
                                          input logic [RC_W-1:0]  r,
                                          input logic [NIB_W-1:0] s);
    logic [KEY_W-1:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = s;
    t[19:15]   = t[19:15] ^ r;
    return t;
  endfunction

  // Exact inverse of fk; s is S^-1(k[79:76])
  function automatic logic [KEY_W-1:0] ik(input logic [KEY_W-1:0] k,
                                          input logic [RC_W-1:0]  r,
                                          input logic [NIB_W-1:0] s);
    logic [KEY_W-1:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ r;
    t[79:76]   = s;
    return {t[60:0], t[79:61]};
  endfunction

  present_sbox u_key_sbox (
    .nib   (key[18:15]),
    .sub_c (key_fwd_nib)
  );

  present_inv_sbox u_key_inv_sbox (
    .nib   (key[79:76]),
    .sub_c (key_inv_nib)
  );

  assign key_fwd  = fk(key, rc, key_fwd_nib);
  assign key_inv  = ik(key, rc, key_inv_nib);
  assign perm_out = inv_perm(state);

  for (genvar g = 0; g < BLOCK_W / NIB_W; g++) begin : g_state_sbox
    present_inv_sbox u_sbox (
      .nib   (perm_out[NIB_W*g +: NIB_W]),
      .sub_c (sub_out[NIB_W*g +: NIB_W])
    );
  end

  assign round_out = sub_out ^ key_inv[79:16];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      ST_IDLE: if (in_valid)        fsm_d = ST_KEXP;
      ST_KEXP: if (rc == LAST_RC)   fsm_d = ST_RUN;
      ST_RUN:  if (rc == FIRST_RC)  fsm_d = ST_DONE;
      ST_DONE: if (out_ready)       fsm_d = ST_IDLE;
      default:                      fsm_d = ST_IDLE;
    endcase
  end

  // Handshake flags decoded from the registered FSM state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture, key expansion with final K32 whitening, inverse rounds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      key   <= '0;
      rc    <= '0;
    end else begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state <= in_ct;
            key   <= in_key;
            rc    <= FIRST_RC;
          end
        end
        ST_KEXP: begin
          key <= key_fwd;
          if (rc == LAST_RC) begin
            state <= state ^ key_fwd[79:16];
          end else begin
            rc <= rc + RC_W'(1);
          end
        end
        ST_RUN: begin
          state <= round_out;
          key   <= key_inv;
          if (rc != FIRST_RC) begin
            rc <= rc - RC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The state register only changes in IDLE/KEXP/RUN, so it is stable through DONE
  assign out_pt = state;

endmodule

// File: tb/tb_present_decrypt.sv
// Self-checking bench for present_decrypt: known-answer table, backpressure,
// mid-operation reset, random round trips against a PRESENT encrypt model, streaming.
module tb_present_decrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_ct = '0;
  logic [79:0] in_key = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  present_decrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ct     (in_ct),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pt    (out_pt)
  );

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // Reference: PRESENT-80 encryption straight from the cipher definition
  function automatic logic [63:0] round_key(input logic [79:0] key, input int r);
    logic [79:0] k;
    k = key;
    for (int i = 1; i < r; i++) begin
      k        = {k[18:0], k[79:19]};
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(i);
    end
    return k[79:16];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[6'(4*n) +: 4] = SB[d[6'(4*n) +: 4]];
    return o;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] d);
    logic [63:0] o;
    int p;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      p = (i == 63) ? 63 : (16 * i) % 63;
      o[6'(p)] = d[6'(i)];
    end
    return o;
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    s = pt;
    for (int r = 1; r <= 31; r++) s = p_layer(s_layer(s ^ round_key(key, r)));
    return s ^ round_key(key, 32);
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("wait_in_ready", 80'(in_ready), 80'(1));
  endtask

  // Accept one block and wait for out_valid; returns plaintext and latency in cycles
  task automatic run_block(input logic [63:0] ct, input logic [79:0] key, input bit hold,
                           output logic [63:0] pt, output int lat);
    wait_ready();
    out_ready = !hold;
    in_ct     = ct;
    in_key    = key;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_ct     = 64'(~ct);
    lat       = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    pt = out_pt;
    if (!hold) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [63:0] ct;
    logic [79:0] key;
    logic [63:0] pt;
  } vec_t;

  vec_t        vecs [4];
  logic [63:0] pt;
  int          lat;

  initial begin
    vecs[0] = '{64'h5579C1387B228445, 80'h0,                    64'h0000000000000000};
    vecs[1] = '{64'hE72C46C0F5945049, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h0000000000000000};
    vecs[2] = '{64'hA112FFC72F68417B, 80'h0,                    64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{64'h3333DCD3213210D2, 80'hFFFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};

    // Reset state
    #23;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 80'(in_ready), 80'(1));
    chk("reset_out_valid", 80'(out_valid), 80'(0));
    chk("reset_out_pt", 80'(out_pt), 80'(0));

    // Known-answer table
    for (int v = 0; v < 4; v++) begin
      run_block(vecs[v].ct, vecs[v].key, 1'b0, pt, lat);
      chk($sformatf("kat%0d_pt", v), 80'(pt), 80'(vecs[v].pt));
      chk($sformatf("kat%0d_latency", v), 80'(lat), 80'(62));
      chk($sformatf("kat%0d_idle_after", v), 80'({in_ready, out_valid}), 80'(2'b10));
    end

    // Backpressure with an ignored in_valid pulse while DONE is held
    run_block(vecs[3].ct, vecs[3].key, 1'b1, pt, lat);
    chk("bp_pt", 80'(pt), 80'(vecs[3].pt));
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_ct    = 64'h0123456789ABCDEF;
        in_key   = 80'h1;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("bp_hold_pt_c%0d", c), 80'(out_pt), 80'(vecs[3].pt));
      chk($sformatf("bp_hold_flags_c%0d", c), 80'({in_ready, out_valid}), 80'(2'b01));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_flags", 80'({in_ready, out_valid}), 80'(2'b10));

    // Asynchronous reset at A+40, then a clean rerun
    wait_ready();
    in_ct    = vecs[0].ct;
    in_key   = vecs[0].key;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    chk("midrun_busy", 80'(in_ready), 80'(0));
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 80'(out_valid), 80'(0));
    chk("midrun_rst_out_pt", 80'(out_pt), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_flags", 80'({in_ready, out_valid}), 80'(2'b10));
    chk("post_rst_out_pt", 80'(out_pt), 80'(0));
    run_block(vecs[0].ct, vecs[0].key, 1'b0, pt, lat);
    chk("rerun_pt", 80'(pt), 80'(vecs[0].pt));
    chk("rerun_latency", 80'(lat), 80'(62));

    // Random round trips through the encrypt model
    for (int r = 0; r < 6; r++) begin
      logic [63:0] rpt;
      logic [79:0] rkey;
      rpt  = {$urandom, $urandom};
      rkey = {16'($urandom), $urandom, $urandom};
      run_block(encrypt(rpt, rkey), rkey, 1'b0, pt, lat);
      chk($sformatf("rand%0d_pt", r), 80'(pt), 80'(rpt));
    end

    // Streaming: in_valid held high, out_ready high
    begin
      logic [63:0] s_pt  [4];
      logic [79:0] s_key [4];
      int acc_cyc [4];
      int out_cyc [4];
      int idx, nout, cyc;
      logic rdy;
      for (int k = 0; k < 4; k++) begin
        s_pt[k]  = {$urandom, $urandom};
        s_key[k] = {16'($urandom), $urandom, $urandom};
        acc_cyc[k] = 0;
        out_cyc[k] = 0;
      end
      wait_ready();
      out_ready = 1'b1;
      idx = 0; nout = 0; cyc = 0;
      in_ct    = encrypt(s_pt[0], s_key[0]);
      in_key   = s_key[0];
      in_valid = 1'b1;
      while (nout < 4 && cyc < 600) begin
        rdy = in_ready;
        @(posedge clk); #1;
        cyc++;
        if (rdy && in_valid) begin
          acc_cyc[idx] = cyc;
          idx++;
          if (idx < 4) begin
            in_ct  = encrypt(s_pt[idx], s_key[idx]);
            in_key = s_key[idx];
          end else begin
            in_valid = 1'b0;
          end
        end
        if (out_valid) begin
          chk($sformatf("stream%0d_pt", nout), 80'(out_pt), 80'(s_pt[nout]));
          out_cyc[nout] = cyc;
          nout++;
        end
      end
      in_valid = 1'b0;
      chk("stream_out_count", 80'(nout), 80'(4));
      for (int k = 1; k < 4; k++)
        chk($sformatf("stream%0d_accept_gap", k), 80'(acc_cyc[k] - acc_cyc[k-1]), 80'(64));
      for (int k = 0; k < 4; k++)
        chk($sformatf("stream%0d_latency", k), 80'(out_cyc[k] - acc_cyc[k]), 80'(62));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/present_decrypt.md
# present_decrypt

Iterative PRESENT-80 block-cipher decryption core: accepts a 64-bit ciphertext and an 80-bit user key, and returns the 64-bit plaintext. It is the decrypt-direction partner of the existing encrypt datapath and its 4-bit forward S-box. It performs one inverse round per clock and uses valid/ready handshakes on input and output.

## Interface
Parameters:
- `ROUNDS`, 31: number of PRESENT rounds. Fixed by the standard and not intended to be overridden.

Ports:
- `clk`  input  1  sole clock; all registers are rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_ct`/`in_key` valid.
- `in_ready`  output  1  core can accept an input (high only in IDLE).
- `in_ct`  input  64  ciphertext.
- `in_key`  input  80  user key K (bit 79 MSB).
- `out_valid`  output  1  `out_pt` valid.
- `out_ready`  input  1  consumer accepts `out_pt`.
- `out_pt`  output  64  plaintext.

## Operation
- **FSM states**: IDLE, KEXP, RUN, DONE. Registers: `state` 64 b, `key` 80 b, `rc` 5 b, FSM state.
- **IDLE**: `in_ready`=1. On `in_valid&&in_ready`: `state`<=`in_ct`, `key`<=`in_key`, `rc`<=1, go to KEXP.
- **KEXP** (forward key schedule, `rc` = 1..31): each cycle the forward update `fk(key, rc)` is applied:
  - rotate left by 61;
  - bits [79:76] <= S(bits [79:76]);
  - bits [19:15] ^= `rc`;
  - `key`<=`fk(key, rc)`.
- **End of KEXP**: when `rc`==31, also `state`<=`state` ^ `fk(key, 31)`[79:16] (this is the K32 whitening). Then `rc` stays 31 and the FSM goes to RUN. Otherwise `rc`<=`rc`+1.
- **RUN** (`rc` = 31..1): compute `pk` = `ik(key, rc)`:
  - bits [19:15] ^= `rc`;
  - [79:76] <= S⁻¹([79:76]);
  - rotate right by 61.
  - Then `state`<=`invS(invP(state))` ^ `pk`[79:16] and `key`<=`pk`.
  - If `rc`==1, go to DONE; else `rc`<=`rc`-1.
- **invP**: `out[i]` = `in[P(i)]`, where P(i) = 16·i mod 63 for i<63 and P(63) = 63.
- **invS**: applied to all 16 nibbles in parallel.
  - S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (index 0..F).
  - S⁻¹ = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- **DONE**: `out_valid`=1 and `out_pt`=`state`. Both are held stable until `out_ready`. On `out_valid&&out_ready`, go to IDLE.
- **No overlap**: a new input is never accepted in the same cycle as the output handshake.
- **`in_valid` while busy**: ignored, since `in_ready`=0. Input buses are sampled only on the accept edge.
- **Reset mid-operation**: an asynchronous `rst_n` low at any state aborts, and the partial result is discarded.
- **Reset values**:
  - FSM = IDLE, so `in_ready`=1 once reset deasserts.
  - `out_valid`=0, `out_pt`=0.
  - `state`, `key`, `rc` = 0.

## Timing
- **Accept**: edge A (`in_valid&&in_ready` sampled high).
- **KEXP**: edges A+1..A+31. RUN: edges A+32..A+62. `out_valid` rises after edge A+62, giving a latency of 62 cycles.
- **Output handshake**: if `out_ready` is already high, the handshake completes at edge A+63. `in_ready` returns after A+63, so the next accept is at A+64 at earliest. Throughput is 1 block per 64 cycles.
- **Backpressure**: `out_ready` low holds DONE indefinitely, with no data change.
- **Output source**: `in_ready` and `out_valid` are decoded from registered FSM state only, with no combinational path from inputs.

## Structure
- **Package `present_pkg`**:
  - `ROUNDS`=31;
  - S and S⁻¹ nibble tables;
  - the FSM state enum;
  - invP as a function over a 64-bit vector.
- **Sub-module `present_inv_sbox`**: 4-bit to 4-bit, instantiated 17 times (16 for state, 1 for key[79:76] in RUN).
- **Forward S-box**: the existing forward S-box module is reused for key[79:76] in KEXP.
- **Key schedule helpers**: `fk` and `ik` are local functions.

## Test plan
- ct=5579C1387B228445, key=0 → `out_pt`=0000000000000000, `out_valid` exactly 62 cycles after accept.
- ct=E72C46C0F5945049, key=FFFF…FF (80 b) → `out_pt`=0000000000000000.
- ct=A112FFC72F68417B, key=0 → `out_pt`=FFFFFFFFFFFFFFFF.
- ct=3333DCD3213210D2, key=all ones → `out_pt`=FFFFFFFFFFFFFFFF:
  - hold `out_ready`=0 for 10 cycles and check `out_pt` is stable;
  - pulse `in_valid` with other data during that window and check it is ignored.
- Assert `rst_n`=0 asynchronously at cycle A+40:
  - check that `out_valid`=0, `out_pt`=0 and `in_ready`=1 immediately after reset deasserts;
  - then re-run vector 1 and check the correct result.
- Back-to-back: 4 vectors are streamed with `in_valid` held high and `out_ready`=1. Each is accepted every 64 cycles, and the outputs arrive in order.
